// File: rtl/neuron_core_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : neuron_core_host_seq
// Description : Bus initiator for the neuron core slave port. Loads the
//               axon weight-type table, streams picture spikes as core
//               writes, closes each picture with a done_pic write, then
//               reads the output-spike word back onto a result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_core_host_seq #(
   parameter logic [8:0] DONE_PIC_ADDR = 9'd448,
   parameter logic [8:0] WEIGHT_BASE   = 9'd464,
   parameter int         WEIGHT_WORDS  = 16,
   parameter logic [8:0] OUT_ADDR      = 9'd480,
   parameter int         SETTLE_CYC    = 4,
   parameter int         READ_LAT      = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_wt_i,
   input  logic        wt_valid_i,
   output logic        wt_ready_o,
   input  logic [31:0] wt_data_i,
   input  logic        spk_valid_i,
   output logic        spk_ready_o,
   input  logic [7:0]  spk_axon_i,
   input  logic        spk_last_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [31:0] res_data_o,
   output logic        busy_o,
   output logic        core_en_o,
   output logic        core_we_o,
   output logic [8:0]  core_addr_o,
   output logic [31:0] core_d_o,
   input  logic [31:0] core_d_i
);

   // Counter preload values; settle and read-latency counters count down to 0.
   localparam logic [7:0] c_WT_LAST     = 8'(WEIGHT_WORDS - 1);
   localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] c_RD_LOAD     = 8'(READ_LAT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WT_LOAD = 3'd1,
      S_SPIKE   = 3'd2,
      S_DONE    = 3'd3,
      S_SETTLE  = 3'd4,
      S_RD_REQ  = 3'd5,
      S_RD_WAIT = 3'd6,
      S_RESULT  = 3'd7
   } state_t;

   state_t      r_state;
   logic [7:0]  r_wcnt;
   logic [7:0]  r_wait;
   logic        r_wt_ready;
   logic        r_spk_ready;
   logic        r_res_valid;
   logic [31:0] r_res_data;
   logic        r_core_en;
   logic        r_core_we;
   logic [8:0]  r_core_addr;
   logic [31:0] r_core_d;

   logic        w_wt_hs;
   logic        w_spk_hs;

   assign w_wt_hs  = wt_valid_i  & r_wt_ready;
   assign w_spk_hs = spk_valid_i & r_spk_ready;

   assign wt_ready_o  = r_wt_ready;
   assign spk_ready_o = r_spk_ready;
   assign res_valid_o = r_res_valid;
   assign res_data_o  = r_res_data;
   assign busy_o      = (r_state != S_IDLE);
   assign core_en_o   = r_core_en;
   assign core_we_o   = r_core_we;
   assign core_addr_o = r_core_addr;
   assign core_d_o    = r_core_d;

   // Sequencer: state, counters and every registered output. Core bus fields
   // default to zero each cycle so a transaction lasts exactly one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_wcnt      <= '0;
         r_wait      <= '0;
         r_wt_ready  <= 1'b0;
         r_spk_ready <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_core_en   <= 1'b0;
         r_core_we   <= 1'b0;
         r_core_addr <= '0;
         r_core_d    <= '0;
      end else begin
         r_core_en   <= 1'b0;
         r_core_we   <= 1'b0;
         r_core_addr <= '0;
         r_core_d    <= '0;
         case (r_state)
            S_IDLE: begin
               // Weight load has priority; a pending spike is left for SPIKE.
               if (load_wt_i) begin
                  r_state    <= S_WT_LOAD;
                  r_wcnt     <= '0;
                  r_wt_ready <= 1'b1;
               end else if (spk_valid_i) begin
                  r_state     <= S_SPIKE;
                  r_spk_ready <= 1'b1;
               end
            end
            S_WT_LOAD: begin
               if (w_wt_hs) begin
                  r_core_en   <= 1'b1;
                  r_core_we   <= 1'b1;
                  r_core_addr <= WEIGHT_BASE + 9'(r_wcnt);
                  r_core_d    <= wt_data_i;
                  r_wcnt      <= r_wcnt + 8'd1;
                  if (r_wcnt == c_WT_LAST) begin
                     r_wt_ready <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_SPIKE: begin
               if (w_spk_hs) begin
                  r_core_en   <= 1'b1;
                  r_core_we   <= 1'b1;
                  r_core_addr <= {1'b0, spk_axon_i};
                  if (spk_last_i) begin
                     r_spk_ready <= 1'b0;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_core_en   <= 1'b1;
               r_core_we   <= 1'b1;
               r_core_addr <= DONE_PIC_ADDR;
               r_wait      <= c_SETTLE_LOAD;
               r_state     <= S_SETTLE;
            end
            S_SETTLE: begin
               if (r_wait == 8'd0) begin
                  r_state <= S_RD_REQ;
               end else begin
                  r_wait <= r_wait - 8'd1;
               end
            end
            S_RD_REQ: begin
               r_core_en   <= 1'b1;
               r_core_addr <= OUT_ADDR;
               r_wait      <= c_RD_LOAD;
               r_state     <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               // Read appears on the bus in the first RD_WAIT cycle; data is
               // valid READ_LAT cycles later.
               if (r_wait == 8'd0) begin
                  r_res_data  <= core_d_i;
                  r_res_valid <= 1'b1;
                  r_state     <= S_RESULT;
               end else begin
                  r_wait <= r_wait - 8'd1;
               end
            end
            S_RESULT: begin
               if (res_ready_i) begin
                  r_res_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_neuron_core_host_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_neuron_core_host_seq
// Description : Directed self-checking bench for neuron_core_host_seq with a
//               bus-transaction scoreboard and a one-cycle-latency core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_core_host_seq;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        load_wt_i, wt_valid_i, spk_valid_i, spk_last_i, res_ready_i;
   logic [31:0] wt_data_i;
   logic [7:0]  spk_axon_i;
   logic        wt_ready_o, spk_ready_o, res_valid_o, busy_o;
   logic        core_en_o, core_we_o;
   logic [31:0] res_data_o, core_d_o;
   logic [8:0]  core_addr_o;
   logic [31:0] core_d_i = 32'h0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          cyc;
      logic        we;
      logic [8:0]  addr;
      logic [31:0] data;
   } tx_t;

   tx_t         exp_q[$];
   tx_t         obs_q[$];
   int          cyc_q[$];
   logic [31:0] res_q[$];
   logic [31:0] rd_val = 32'h0;
   tx_t         mon_t;

   always #5 clk = ~clk;

   neuron_core_host_seq dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .load_wt_i   (load_wt_i),
      .wt_valid_i  (wt_valid_i),
      .wt_ready_o  (wt_ready_o),
      .wt_data_i   (wt_data_i),
      .spk_valid_i (spk_valid_i),
      .spk_ready_o (spk_ready_o),
      .spk_axon_i  (spk_axon_i),
      .spk_last_i  (spk_last_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_data_o  (res_data_o),
      .busy_o      (busy_o),
      .core_en_o   (core_en_o),
      .core_we_o   (core_we_o),
      .core_addr_o (core_addr_o),
      .core_d_o    (core_d_o),
      .core_d_i    (core_d_i)
   );

   // cycle stamp for transaction spacing
   always @(posedge clk) cyc <= cyc + 1;

   // core read model: data valid exactly one cycle after the read request
   always @(posedge clk)
      core_d_i <= (core_en_o && !core_we_o) ?
                  ((core_addr_o == 9'd480) ? rd_val : 32'hDEAD_BEEF) : 32'h0;

   // bus monitor: log every transaction away from the active edge
   always @(negedge clk) begin
      if (core_en_o) begin
         mon_t.cyc  = cyc;
         mon_t.we   = core_we_o;
         mon_t.addr = core_addr_o;
         mon_t.data = core_d_o;
         obs_q.push_back(mon_t);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic we, input logic [8:0] addr, input logic [31:0] data);
      tx_t t;
      t.cyc = 0; t.we = we; t.addr = addr; t.data = data;
      exp_q.push_back(t);
   endtask

   task automatic send_wt(input logic [31:0] d);
      logic h;
      int   b;
      b = 0;
      wt_valid_i = 1'b1;
      wt_data_i  = d;
      do begin
         @(negedge clk);
         h = wt_ready_o;
         @(posedge clk); #1;
         b++;
      end while (!h && b < 50);
      if (!h) chk("wt_handshake", {63'd0, h}, 64'd1);
      wt_valid_i = 1'b0;
   endtask

   task automatic send_spk(input logic [7:0] ax, input logic last);
      logic h;
      int   b;
      b = 0;
      spk_valid_i = 1'b1;
      spk_axon_i  = ax;
      spk_last_i  = last;
      do begin
         @(negedge clk);
         h = spk_ready_o;
         @(posedge clk); #1;
         b++;
      end while (!h && b < 50);
      if (!h) chk("spk_handshake", {63'd0, h}, 64'd1);
      spk_valid_i = 1'b0;
      spk_last_i  = 1'b0;
   endtask

   task automatic compare_txs(input string tag);
      int n;
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      cyc_q.delete();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_tx%0d", tag, i),
             {22'd0, obs_q[i].we, obs_q[i].addr, obs_q[i].data},
             {22'd0, exp_q[i].we, exp_q[i].addr, exp_q[i].data});
         cyc_q.push_back(obs_q[i].cyc);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_result(input string tag);
      int b;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (!res_valid_o && b < 60);
      chk({tag, "_valid"}, {63'd0, res_valid_o}, 64'd1);
      if (res_q.size() > 0) chk({tag, "_data"}, {32'd0, res_data_o}, {32'd0, res_q.pop_front()});
   endtask

   task automatic finish_result(input string tag);
      @(posedge clk); #1;
      res_ready_i = 1'b1;
      @(posedge clk); #1;
      res_ready_i = 1'b0;
      @(negedge clk);
      chk({tag, "_after_ack"}, {62'd0, res_valid_o, busy_o}, 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {17'd0, res_valid_o, busy_o, wt_ready_o, spk_ready_o,
                          core_en_o, core_we_o, core_addr_o, res_data_o}, 64'd0);
      chk({tag, "_dout"}, {32'd0, core_d_o}, 64'd0);
   endtask

   initial begin
      rst_ni = 1'b0; load_wt_i = 1'b0; wt_valid_i = 1'b0; wt_data_i = '0;
      spk_valid_i = 1'b0; spk_axon_i = '0; spk_last_i = 1'b0; res_ready_i = 1'b0;
      step(2);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst_ni = 1'b1;
      step(1);

      // T1: full weight table load with one gap in valid
      load_wt_i = 1'b1;
      step(1);
      load_wt_i = 1'b0;
      @(negedge clk);
      chk("t1_enter", {62'd0, busy_o, wt_ready_o}, 64'd3);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         push_tx(1'b1, 9'(464 + i), 32'hA5A5_0000 + 32'(i));
         if (i == 5) step(2);
         send_wt(32'hA5A5_0000 + 32'(i));
      end
      @(negedge clk);
      chk("t1_exit", {62'd0, busy_o, wt_ready_o}, 64'd0);
      step(2);
      compare_txs("t1");

      // T2/T3: back-to-back picture, then held result
      rd_val = 32'h8000_0001;
      push_tx(1'b1, 9'd3, 32'h0);
      push_tx(1'b1, 9'd7, 32'h0);
      push_tx(1'b1, 9'd255, 32'h0);
      push_tx(1'b1, 9'd448, 32'h0);
      push_tx(1'b0, 9'd480, 32'h0);
      res_q.push_back(32'h8000_0001);
      send_spk(8'd3, 1'b0);
      send_spk(8'd7, 1'b0);
      send_spk(8'd255, 1'b1);
      @(negedge clk);
      chk("t2_spk_ready_drop", {62'd0, spk_ready_o, busy_o}, 64'd1);
      wait_result("t3");
      compare_txs("t2");
      if (cyc_q.size() == 5) begin
         chk("t2_gap_3_7",     64'(cyc_q[1] - cyc_q[0]), 64'd1);
         chk("t2_gap_7_255",   64'(cyc_q[2] - cyc_q[1]), 64'd1);
         chk("t2_gap_255_448", 64'(cyc_q[3] - cyc_q[2]), 64'd1);
         chk("t2_gap_448_rd",  64'(cyc_q[4] - cyc_q[3]), 64'd5);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t3_hold%0d", i), {31'd0, res_valid_o, res_data_o}, {31'd0, 1'b1, 32'h8000_0001});
      end
      finish_result("t3");

      // T4: load and spike together in IDLE -> weight load first
      load_wt_i = 1'b1;
      spk_valid_i = 1'b1; spk_axon_i = 8'd9; spk_last_i = 1'b1;
      step(1);
      load_wt_i = 1'b0;
      @(negedge clk);
      chk("t4_priority", {61'd0, busy_o, wt_ready_o, spk_ready_o}, 64'd6);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         push_tx(1'b1, 9'(464 + i), 32'h0F0F_0000 ^ 32'(i * 3));
         send_wt(32'h0F0F_0000 ^ 32'(i * 3));
         chk($sformatf("t4_spk_ready_low%0d", i), {63'd0, spk_ready_o}, 64'd0);
      end
      rd_val = 32'h1234_5678;
      push_tx(1'b1, 9'd9, 32'h0);
      push_tx(1'b1, 9'd448, 32'h0);
      push_tx(1'b0, 9'd480, 32'h0);
      res_q.push_back(32'h1234_5678);
      send_spk(8'd9, 1'b1);
      wait_result("t4");
      compare_txs("t4");
      finish_result("t4");

      // T5: single spike on axon 0
      rd_val = 32'h0000_00F0;
      push_tx(1'b1, 9'd0, 32'h0);
      push_tx(1'b1, 9'd448, 32'h0);
      push_tx(1'b0, 9'd480, 32'h0);
      res_q.push_back(32'h0000_00F0);
      send_spk(8'd0, 1'b1);
      wait_result("t5");
      compare_txs("t5");
      finish_result("t5");

      // T6a: reset during SETTLE
      push_tx(1'b1, 9'd5, 32'h0);
      push_tx(1'b1, 9'd448, 32'h0);
      send_spk(8'd5, 1'b1);
      step(2);
      @(negedge clk); #2;
      rst_ni = 1'b0;
      #1;
      chk_all_zero("t6a_rst");
      step(2);
      rst_ni = 1'b1;
      step(10);
      chk("t6a_idle", {62'd0, busy_o, res_valid_o}, 64'd0);
      compare_txs("t6a");

      // T6b: reset while word 5 of a weight load is offered
      load_wt_i = 1'b1;
      step(1);
      load_wt_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_tx(1'b1, 9'(464 + i), 32'h5555_0000 + 32'(i));
         send_wt(32'h5555_0000 + 32'(i));
      end
      wt_valid_i = 1'b1;
      wt_data_i  = 32'h5555_0005;
      @(negedge clk); #2;
      rst_ni = 1'b0;
      #1;
      chk_all_zero("t6b_rst");
      wt_valid_i = 1'b0;
      step(2);
      rst_ni = 1'b1;
      step(10);
      chk("t6b_idle", {62'd0, busy_o, wt_ready_o}, 64'd0);
      compare_txs("t6b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
